fifo_rd_arbiter: RTL and testbench



---
 rtl/fifo_rd_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin arbiter for the read side of the async FIFO.
// One consumer is granted at a time for a burst of up to MAX_BURST words.
// The FIFO read enable comes from the granted consumer's readiness and the
// empty flag. Each read word is routed to that consumer with a one-hot strobe.
//
// Optional build macro: FIFO_RD_ARB_WATCHDOG_EN. When it is defined, a grant
// stalled for TIMEOUT cycles is force-released and timeout pulses.
//
// Ports:
//   clk        read-domain clock
//   rst        synchronous active-high reset
//   req        per-consumer request (level)
//   rdy        per-consumer ready; the consumer takes a word the next cycle
//   r_empty    FIFO empty flag
//   r_data     FIFO read data, valid the cycle after r_en
//   r_en       FIFO read enable (combinational)
//   gnt        one-hot grant (registered)
//   out_data   r_data pass-through
//   out_valid  one-hot word strobe (registered)
//   timeout    one-cycle pulse on watchdog release, else constant 0
module fifo_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    rdy,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic                  timeout
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0]    CntMax  = CntW'(MAX_BURST);
  localparam logic [CntW-1:0]    CntLast = CntW'(MAX_BURST - 1);
  localparam logic [PtrW-1:0]    PtrLast = PtrW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GntOne  = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_rd_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StBurst, StRelease} state_e;

  state_e                 state;
  logic [PtrW-1:0]        ptr;
  logic [CntW-1:0]        cnt;
  logic [PtrW-1:0]        ptr_nxt;
  logic [PtrW-1:0]        pick;
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [2*NUM_REQ-1:0]   req_rot;
  logic                   req_g;
  logic                   rdy_g;

  // Round-robin search starts at ptr+1. Rotate a doubled copy of req so that
  // bit 0 is the highest-priority candidate.
  assign ptr_nxt = (ptr == PtrLast) ? '0 : ptr + 1'b1;
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr_nxt;

  always_comb begin
    pick = ptr_nxt;
    // Scan downwards so that the lowest rotated position wins.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) pick = PtrW'((int'(ptr_nxt) + j) % NUM_REQ);
    end
  end

  // gnt is one-hot in BURST/RELEASE, so these select the granted consumer.
  assign req_g = |(req & gnt);
  assign rdy_g = |(rdy & gnt);

  assign r_en     = (state == StBurst) && req_g && rdy_g && !r_empty && (cnt < CntMax);
  assign out_data = r_data;

`ifdef FIFO_RD_ARB_WATCHDOG_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);
  localparam logic [StallW-1:0] StallLast = StallW'(TIMEOUT - 1);

  logic [StallW-1:0] stall_cnt;
  logic              timeout_q;
  logic              stall;

  assign stall   = (state == StBurst) && req_g && !rdy_g && !r_empty;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      ptr       <= PtrLast;
      cnt       <= '0;
      gnt       <= '0;
      out_valid <= '0;
`ifdef FIFO_RD_ARB_WATCHDOG_EN
      stall_cnt <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      out_valid <= gnt & {NUM_REQ{r_en}};
`ifdef FIFO_RD_ARB_WATCHDOG_EN
      timeout_q <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
`ifdef FIFO_RD_ARB_WATCHDOG_EN
          stall_cnt <= '0;
`endif
          if (|req && !r_empty) begin
            gnt   <= GntOne << pick;
            ptr   <= pick;
            cnt   <= '0;
            state <= StBurst;
          end
        end
        StBurst: begin
          if (r_en) cnt <= cnt + 1'b1;
          if ((r_en && cnt == CntLast) || !req_g || r_empty) begin
            state <= StRelease;
          end
`ifdef FIFO_RD_ARB_WATCHDOG_EN
          else if (stall && stall_cnt == StallLast) begin
            state     <= StRelease;
            timeout_q <= 1'b1;
          end
          if (r_en) begin
            stall_cnt <= '0;
          end else if (stall) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        StRelease: begin
          // gnt was held one extra cycle so the last in-flight word is routed.
          gnt   <= '0;
          state <= StIdle;
        end
        default: begin
          gnt   <= '0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter (NUM_REQ=4, MAX_BURST=4, TIMEOUT=16).
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] rdy;
  logic       r_empty;
  logic [7:0] r_data;
  logic       r_en;
  logic [3:0] gnt;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic       timeout;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rdy       (rdy),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] rdy;
    logic       empty;
    logic       ren;
    logic [3:0] gnt;
    logic [3:0] ov;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] y, input logic e,
                     input logic en, input logic [3:0] g, input logic [3:0] ov);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = y; v.empty = e; v.ren = en; v.gnt = g; v.ov = ov;
    vecs.push_back(v);
  endtask

  initial begin
    // The 8-word FIFO serves req[0] then req[2]: 4 reads each, with a 2-cycle gap.
    add(0, 4'b0101, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0001, 4'b0000);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'hf, 0, 0, 4'b0001, 4'b0001);
    add(0, 4'b0101, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0100, 4'b0000);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0100, 4'b0100);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0100, 4'b0100);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0100, 4'b0100);
    add(0, 4'b0101, 4'hf, 1, 0, 4'b0100, 4'b0100);
    add(0, 4'b0000, 4'hf, 1, 0, 4'b0000, 4'b0000);
    // Single requester with 2 words in the FIFO: empty ends the burst early.
    add(0, 4'b0010, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 4'hf, 0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'hf, 0, 1, 4'b0010, 4'b0010);
    add(0, 4'b0010, 4'hf, 1, 0, 4'b0010, 4'b0010);
    add(0, 4'b0010, 4'hf, 1, 0, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'hf, 1, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'hf, 1, 0, 4'b0000, 4'b0000);
    // rdy[3] drops for 3 cycles mid-burst; the burst still totals 4 words.
    add(0, 4'b1000, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b1000, 4'hf, 0, 1, 4'b1000, 4'b0000);
    add(0, 4'b1000, 4'h7, 0, 0, 4'b1000, 4'b1000);
    add(0, 4'b1000, 4'h7, 0, 0, 4'b1000, 4'b0000);
    add(0, 4'b1000, 4'h7, 0, 0, 4'b1000, 4'b0000);
    add(0, 4'b1000, 4'hf, 0, 1, 4'b1000, 4'b0000);
    add(0, 4'b1000, 4'hf, 0, 1, 4'b1000, 4'b1000);
    add(0, 4'b1000, 4'hf, 0, 1, 4'b1000, 4'b1000);
    add(0, 4'b1000, 4'hf, 0, 0, 4'b1000, 4'b1000);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0000, 4'b0000);
    // req[0] drops after one word; the in-flight word is still strobed.
    add(0, 4'b0001, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'hf, 0, 1, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0001, 4'b0001);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0000, 4'b0000);
    // Reset mid-burst: outputs clear and ptr returns to NUM_REQ-1, so req[0] wins.
    add(0, 4'b0100, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'hf, 0, 1, 4'b0100, 4'b0000);
    add(1, 4'b0100, 4'hf, 0, 1, 4'b0100, 4'b0100);
    add(0, 4'b0101, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0101, 4'hf, 0, 1, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0001, 4'b0001);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'hf, 0, 0, 4'b0000, 4'b0000);
    // req drop coincides with empty rising: one RELEASE, then IDLE.
    add(0, 4'b0010, 4'hf, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 4'hf, 0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'hf, 1, 0, 4'b0010, 4'b0010);
    add(0, 4'b0000, 4'hf, 1, 0, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'hf, 1, 0, 4'b0000, 4'b0000);

    // Reset with every input active: nothing may be granted or read.
    rst = 1'b1; req = 4'hf; rdy = 4'hf; r_empty = 1'b0; r_data = 8'h5a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (r_en !== 1'b0 || gnt !== 4'b0 || out_valid !== 4'b0 || timeout !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_state cycle %0d: got r_en=%b gnt=%b out_valid=%b timeout=%b, want 0 0000 0000 0",
                 k, r_en, gnt, out_valid, timeout);
      end
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; rdy = vecs[i].rdy; r_empty = vecs[i].empty;
      r_data = 8'(i + 48);
      #1;
      n_vec++;
      if (r_en !== vecs[i].ren || gnt !== vecs[i].gnt || out_valid !== vecs[i].ov ||
          timeout !== 1'b0 || (vecs[i].ov != 4'b0 && out_data !== 8'(i + 48))) begin
        n_miss++;
        $display("FAIL vector %0d: got r_en=%b gnt=%b out_valid=%b timeout=%b data=%h, want %b %b %b 0 %h",
                 i, r_en, gnt, out_valid, timeout, out_data, vecs[i].ren, vecs[i].gnt,
                 vecs[i].ov, 8'(i + 48));
      end
    end

`ifdef FIFO_RD_ARB_WATCHDOG_EN
    // ptr is 1 here, so req[0] is granted. It stalls 16 cycles, then req[1] should win.
    begin
      int         pulses = 0;
      logic       seen   = 1'b0;
      logic [3:0] next_g = 4'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        rst = 1'b0; req = 4'b0011; rdy = 4'h0; r_empty = 1'b0;
        #1;
        if (seen && gnt != 4'b0 && next_g == 4'b0) next_g = gnt;
        if (timeout === 1'b1) begin
          pulses++;
          seen = 1'b1;
        end
      end
      n_vec++;
      if (pulses != 1) begin
        n_miss++;
        $display("FAIL watchdog_pulse: got %0d timeout pulses, want 1", pulses);
      end
      n_vec++;
      if (next_g !== 4'b0010) begin
        n_miss++;
        $display("FAIL watchdog_next_grant: got gnt=%b, want 0010", next_g);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
